esp_burst_sequencer: RTL and testbench

- Upstream stage that drives the ESP storage bridge.
- Accepts one host burst request (read or write, start address, length) and splits it into single-byte 28-bit ESP command words.
- Presents each command word on the bridge's command input and waits for the bridge's tagged valid response before moving on.
- Write bursts take bytes from a valid/ready stream. Read bursts return bytes on a valid/ready stream.

---
 rtl/esp_pkg.sv | 43 ++++
 rtl/esp_rsp_match.sv | 26 ++
 rtl/esp_burst_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_esp_burst_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esp_pkg.sv
// Shared ESP command-word layout, opcodes and sequencer state encoding.
package esp_pkg;

    localparam logic [2:0] OP_WRITE  = 3'b001;
    localparam logic [2:0] OP_READ   = 3'b010;
    localparam logic [2:0] OP_COMMIT = 3'b011;

    localparam int unsigned WORD_W   = 28;
    localparam int unsigned FLAG_BIT = 27;
    localparam int unsigned OP_MSB   = 26;
    localparam int unsigned OP_LSB   = 24;
    localparam int unsigned DATA_MSB = 23;
    localparam int unsigned DATA_LSB = 16;
    localparam int unsigned ADDR_MSB = 15;
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned TAG_W    = 8;

    localparam logic [WORD_W-1:0] ESP_INIT_WORD = 28'h8FF0000;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWaitRsp,
        StDeliver,
        StNext,
        StCommit,
        StFinish
    } esp_state_e;

    // Request words always leave the response flag clear.
    function automatic logic [WORD_W-1:0] esp_cmd(input logic [2:0]  op,
                                                  input logic [7:0]  data,
                                                  input logic [15:0] addr);
        logic [WORD_W-1:0] w;
        w                     = '0;
        w[OP_MSB:OP_LSB]      = op;
        w[DATA_MSB:DATA_LSB]  = data;
        w[ADDR_MSB:ADDR_LSB]  = addr;
        return w;
    endfunction

endpackage

// File: rtl/esp_rsp_match.sv
// Accepts a bridge response once per rising edge of its valid, if flagged and tag-matched.
module esp_rsp_match
    import esp_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rsp_valid_i,
    input  logic             rsp_flag_i,
    input  logic [TAG_W-1:0] rsp_tag_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             accept_o
);

    logic valid_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_prev_q <= 1'b0;
        end else begin
            valid_prev_q <= rsp_valid_i;
        end
    end

    assign accept_o = rsp_valid_i & ~valid_prev_q & rsp_flag_i & (rsp_tag_i == tag_i);

endmodule

// File: rtl/esp_burst_sequencer.sv
// Splits a host burst into single-byte ESP commands with timeout/retry handling.
// Define ESP_SEQ_COMMIT_EN to terminate every write burst with a commit command.
module esp_burst_sequencer
    import esp_pkg::*;
#(
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [15:0]       req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] esp_req,
    input  logic [WORD_W-1:0] esp_rsp,
    input  logic              esp_rsp_valid,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

    esp_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [15:0]       addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [WORD_W-1:0] esp_req_q, esp_req_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              err_q, err_d;
    logic              commit_q, commit_d;
    logic              rsp_match;
    logic              accept;
    logic              unused_rsp_bits;

    esp_rsp_match u_rsp_match (
        .clk_i       (clk),
        .rst_i       (reset),
        .rsp_valid_i (esp_rsp_valid),
        .rsp_flag_i  (esp_rsp[FLAG_BIT]),
        .rsp_tag_i   (esp_rsp[TAG_W-1:0]),
        .tag_i       (esp_req_q[TAG_W-1:0]),
        .accept_o    (rsp_match)
    );

    assign accept          = rsp_match & (state_q == StWaitRsp);
    assign unused_rsp_bits = ^{esp_rsp[OP_MSB:OP_LSB], esp_rsp[ADDR_MSB:TAG_W]};

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        esp_req_d = esp_req_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        err_d     = err_q;
        commit_d  = commit_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d  = req_write;
                    addr_d   = req_addr;
                    rem_d    = req_len;
                    retry_d  = '0;
                    err_d    = 1'b0;
                    commit_d = 1'b0;
                    state_d  = req_write ? StFetch : StIssue;
                end
            end
            StFetch: begin
                if (wr_valid) begin
                    wdata_d = wr_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (commit_q) begin
                    esp_req_d = esp_cmd(OP_COMMIT, 8'h00, addr_q);
                end else if (write_q) begin
                    esp_req_d = esp_cmd(OP_WRITE, wdata_q, addr_q);
                end else begin
                    esp_req_d = esp_cmd(OP_READ, 8'h00, addr_q);
                end
                tmo_d   = '0;
                state_d = StWaitRsp;
            end
            StWaitRsp: begin
                tmo_d = tmo_q + TMO_W'(1);
                // A response arriving on the timeout cycle still wins.
                if (accept) begin
                    if (commit_q) begin
                        state_d = StFinish;
                    end else if (write_q) begin
                        state_d = StNext;
                    end else begin
                        rdata_d = esp_rsp[DATA_MSB:DATA_LSB];
                        state_d = StDeliver;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = StIssue;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end
                end
            end
            StDeliver: begin
                if (rd_ready) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                retry_d = '0;
                if (rem_q == '0) begin
`ifdef ESP_SEQ_COMMIT_EN
                    state_d = write_q ? StCommit : StFinish;
`else
                    state_d = StFinish;
`endif
                end else begin
                    addr_d  = addr_q + 16'd1;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = write_q ? StFetch : StIssue;
                end
            end
`ifdef ESP_SEQ_COMMIT_EN
            StCommit: begin
                // addr_q still holds the last byte address, which becomes the commit tag.
                commit_d = 1'b1;
                state_d  = StIssue;
            end
`endif
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            write_q   <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            esp_req_q <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            err_q     <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            esp_req_q <= esp_req_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
            commit_q  <= commit_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign req_ready = (state_q == StIdle) & ~reset;
    assign wr_ready  = (state_q == StFetch) & ~reset;
    assign rd_valid  = (state_q == StDeliver) & ~reset;
    assign busy      = (state_q != StIdle) & ~reset;
    assign done      = (state_q == StFinish) & ~reset;
    assign error     = done & err_q;
    assign rd_data   = rdata_q;
    assign esp_req   = esp_req_q;

endmodule

// File: tb/tb_esp_burst_sequencer.sv
// Directed bench for esp_burst_sequencer: bridge/host models plus a per-cycle checker.
module tb_esp_burst_sequencer;

    localparam int unsigned LEN_W     = 8;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned MAX_RETRY = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [15:0]      req_addr = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic [7:0]       wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b1;
    logic [27:0]      esp_req;
    logic [27:0]      esp_rsp = '0;
    logic             esp_rsp_valid = 1'b0;
    logic             busy;
    logic             done;
    logic             error;

    always #5 clk = ~clk;

    esp_burst_sequencer #(
        .LEN_W     (LEN_W),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .esp_req       (esp_req),
        .esp_rsp       (esp_rsp),
        .esp_rsp_valid (esp_rsp_valid),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    int n_vec = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Bridge memory contents and the expected command-word format.
    function automatic logic [7:0] rd_mem(input logic [15:0] a);
        return a[7:0] + 8'h90;
    endfunction

    function automatic logic [27:0] model_word(input logic [2:0] op, input logic [7:0] d,
                                               input logic [15:0] a);
        return {1'b0, op, d, a};
    endfunction

    function automatic logic [27:0] resp_of(input logic [27:0] w);
        logic [7:0] d;
        d = (w[26:24] == 3'b010) ? rd_mem(w[15:0]) : 8'h00;
        return {1'b1, w[26:24], d, w[15:0]};
    endfunction

    logic [27:0] exp_w[$];
    logic [7:0]  exp_rd[$];
    logic [27:0] seen_w[$];
    logic [7:0]  seen_rd[$];
    bit          exp_err = 1'b0;
    int          done_cnt = 0;

    int          rsp_mode = 0;   // 0 respond after 2 cycles, 1 silent, 2 wrong-tag then stuck valid
    logic [7:0]  wbytes[4];
    int          wr_len = 0;
    int          wr_gen = 0;
    int          bp_cycles = 0;

    // Bridge, write-source and read-sink models; drive on the falling edge.
    logic [27:0] d_last = '0;
    logic [27:0] d_cur = '0;
    int          d_step = 0;
    bit          d_act = 1'b0;
    bit          d_scr = 1'b0;
    int          w_idx = 0;
    int          w_gen_seen = 0;
    bit          w_hs = 1'b0;
    int          r_held = 0;

    always begin
        @(negedge clk);
        if (esp_req !== d_last) begin
            d_last = esp_req;
            d_cur  = esp_req;
            d_act  = (esp_req != 28'h0) && (rsp_mode != 1);
            d_scr  = (rsp_mode == 2) && (esp_req[7:0] == 8'h10);
            d_step = 0;
        end else if (d_act) begin
            d_step++;
        end
        esp_rsp_valid = 1'b0;
        if (d_act) begin
            esp_rsp = resp_of(d_cur);
            if (d_scr) begin
                if (d_step == 0) begin
                    esp_rsp_valid = 1'b1;
                    esp_rsp[7:0]  = 8'h55;
                end else if (d_step >= 2 && d_step <= 6) begin
                    esp_rsp_valid = 1'b1;
                end else if (d_step > 6) begin
                    d_act = 1'b0;
                end
            end else begin
                if (d_step == 2) esp_rsp_valid = 1'b1;
                else if (d_step > 2) d_act = 1'b0;
            end
        end

        if (wr_gen != w_gen_seen) begin
            w_gen_seen = wr_gen;
            w_idx      = 0;
            w_hs       = 1'b0;
        end
        if (w_hs) w_idx++;
        wr_valid = (w_idx < wr_len);
        wr_data  = (w_idx < 4) ? wbytes[w_idx] : 8'h00;
        w_hs     = wr_valid && wr_ready;

        if (rd_valid) begin
            if (r_held < bp_cycles) begin
                rd_ready = 1'b0;
                r_held++;
            end else begin
                rd_ready = 1'b1;
            end
        end else begin
            r_held   = 0;
            rd_ready = (bp_cycles == 0);
        end
    end

    // Per-cycle checker, sampled just before the rising edge.
    logic [27:0] c_last = '0;
    bit          c_prev_rv = 1'b0;
    bit          c_prev_hs = 1'b0;
    logic [7:0]  c_prev_rd = '0;
    logic [27:0] c_prev_req = '0;

    always begin
        @(negedge clk);
        #3;
        if (!reset) begin
            check("req_ready_vs_busy", {31'b0, req_ready}, {31'b0, !busy});
            if (esp_req !== c_last) begin
                c_last = esp_req;
                if (esp_req != 28'h0) begin
                    seen_w.push_back(esp_req);
                    if (exp_w.size() > 0) check("esp_req", esp_req, exp_w.pop_front());
                    else check("esp_req_extra", esp_req, 32'h0);
                end
            end
            if (rd_valid && c_prev_rv && !c_prev_hs) begin
                check("rd_data_hold", rd_data, c_prev_rd);
                check("esp_req_hold", esp_req, c_prev_req);
            end
            if (rd_valid && rd_ready) begin
                seen_rd.push_back(rd_data);
                if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
                else check("rd_extra", {31'b0, rd_valid}, 32'h0);
            end
            if (done) begin
                check("error_at_done", {31'b0, error}, {31'b0, exp_err});
                done_cnt++;
            end else if (error) begin
                check("error_without_done", {31'b0, done}, 32'h1);
            end
            c_prev_rv  = rd_valid;
            c_prev_hs  = rd_valid && rd_ready;
            c_prev_rd  = rd_data;
            c_prev_req = esp_req;
        end else begin
            c_prev_rv = 1'b0;
            c_prev_hs = 1'b0;
        end
    end

    task automatic start_burst(input bit wr, input logic [15:0] addr, input int len,
                               input bit err, input bit expect_rd);
        logic [15:0] a;
        check("req_ready_before", {31'b0, req_ready}, 32'h1);
        exp_err = err;
        for (int i = 0; i <= len; i++) begin
            a = addr + 16'(i);
            if (wr) begin
                exp_w.push_back(model_word(3'b001, wbytes[i], a));
            end else begin
                exp_w.push_back(model_word(3'b010, 8'h00, a));
                if (expect_rd) exp_rd.push_back(rd_mem(a));
            end
        end
`ifdef ESP_SEQ_COMMIT_EN
        if (wr) exp_w.push_back(model_word(3'b011, 8'h00, addr + 16'(len)));
`endif
        if (wr) begin
            wr_len = len + 1;
            wr_gen++;
        end
        seen_w.delete();
        seen_rd.delete();
        req_write = wr;
        req_addr  = addr;
        req_len   = LEN_W'(len);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        int d0;
        d0  = done_cnt;
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) check("done_timeout", {31'b0, done}, 32'h1);
        @(posedge clk);
        #1;
        check("done_count", done_cnt - d0, 32'h1);
        check("queues_drained", exp_w.size() + exp_rd.size(), 32'h0);
        check("req_ready_after", {31'b0, req_ready}, 32'h1);
        check("busy_after", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int cyc;
        int d0;
        bit found;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_error", {31'b0, error}, 32'h0);
        check("rst_esp_req", esp_req, 32'h0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("rst_wr_ready", {31'b0, wr_ready}, 32'h0);
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_req_ready", {31'b0, req_ready}, 32'h1);

        // Read burst, 4 bytes at 0x0010.
        start_burst(1'b0, 16'h0010, 3, 1'b0, 1'b1);
        wait_done(200, cyc);
        check("read_done_cycle", cyc, 32'd24);
        check("read_word_cnt", seen_w.size(), 32'd4);
        check("read_word0", seen_w[0], 32'h2000010);
        check("read_word3", seen_w[3], 32'h2000013);
        check("read_byte0", seen_rd[0], 32'hA0);
        check("read_byte3", seen_rd[3], 32'hA3);

        // Write burst wrapping 0xFFFF -> 0x0000.
        wbytes[0] = 8'h11;
        wbytes[1] = 8'h22;
        wbytes[2] = 8'h33;
        wbytes[3] = 8'h44;
        start_burst(1'b1, 16'hFFFE, 2, 1'b0, 1'b0);
        wait_done(200, cyc);
        check("write_word0", seen_w[0], 32'h111FFFE);
        check("write_word2", seen_w[2], 32'h1330000);
`ifdef ESP_SEQ_COMMIT_EN
        check("write_word_cnt", seen_w.size(), 32'd4);
        check("commit_word", seen_w[3], 32'h3000000);
`else
        check("write_word_cnt", seen_w.size(), 32'd3);
`endif

        // Wrong tag, then a correct response held valid for 5 cycles.
        rsp_mode  = 2;
        bp_cycles = 3;
        start_burst(1'b0, 16'h0010, 1, 1'b0, 1'b1);
        wait_done(200, cyc);
        check("tag_word_cnt", seen_w.size(), 32'd2);
        check("tag_byte_cnt", seen_rd.size(), 32'd2);
        check("tag_byte0", seen_rd[0], 32'hA0);

        // Read backpressure.
        rsp_mode  = 0;
        bp_cycles = 10;
        start_burst(1'b0, 16'h0200, 1, 1'b0, 1'b1);
        wait_done(300, cyc);
        check("bp_done_cycle", cyc, 32'd32);
        bp_cycles = 0;

        // No response ever: 1 + MAX_RETRY issues, then done with error.
        rsp_mode = 1;
        start_burst(1'b0, 16'h0400, 0, 1'b1, 1'b0);
        wait_done(200, cyc);
        check("timeout_done_cycle", cyc, 32'd68);
        check("timeout_word_cnt", seen_w.size(), 32'd1);
        rsp_mode = 0;

        // Reset while waiting on the second byte's response.
        start_burst(1'b0, 16'h0300, 3, 1'b0, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (esp_req[15:0] == 16'h0301) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_byte2", {31'b0, found}, 32'h1);
        d0    = done_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_esp_req", esp_req, 32'h0);
        check("midrst_rd_valid", {31'b0, rd_valid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_w.delete();
        exp_rd.delete();
        @(posedge clk);
        #1;
        check("postrst_req_ready", {31'b0, req_ready}, 32'h1);
        check("postrst_esp_req", esp_req, 32'h0);
        check("postrst_no_done", done_cnt - d0, 32'h0);

        // Recovery burst after the abort.
        start_burst(1'b0, 16'h0500, 0, 1'b0, 1'b1);
        wait_done(100, cyc);
        check("recover_byte", seen_rd[0], 32'h90);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
